result_streamer: RTL and testbench

RESULT_STREAMER -- requirements
Module: result_streamer

---
 rtl/result_streamer_pkg.sv | 17 +
 rtl/result_streamer_if.sv | 34 +++
 rtl/result_streamer.sv | 136 +++++++++++++
 tb/tb_result_streamer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_streamer_pkg.sv
// result_streamer_pkg: state encoding and element width shared
// by the streamer, its stream interface and the bench.
package result_streamer_pkg;

  localparam int ELEM_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_FETCH  = 3'd4,
    S_SEND   = 3'd5,
    S_FINISH = 3'd6
  } state_t;

endpackage

// File: rtl/result_streamer_if.sv
// result_streamer_if: valid/ready stream of result elements
// tagged with their row/column and an end-of-matrix flag.
interface result_streamer_if
  import result_streamer_pkg::*;
#(
  parameter int n_len = 4
) ();

  logic [ELEM_W-1:0] out_data;
  logic [n_len-1:0]  out_row;
  logic [n_len-1:0]  out_col;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_row,
    output out_col,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/result_streamer.sv
// result_streamer: starts the multiplier, then drains its n x n
// result row-major over a valid/ready stream with a running checksum.
module result_streamer
  import result_streamer_pkg::*;
#(
  parameter int n     = 10,
  parameter int n_len = (n > 1) ? $clog2(n) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              mul_start,
  input  logic              mul_done,
  output logic [n_len-1:0]  z_i,
  output logic [n_len-1:0]  z_j,
  input  logic [ELEM_W-1:0] z_out,
  result_streamer_if.master out_s,
  output logic              busy,
  output logic [ELEM_W-1:0] checksum,
  output logic              checksum_valid
);

  localparam logic [n_len-1:0] LAST = n_len'(n - 1);

  state_t state;
  state_t state_n;

  logic [ELEM_W-1:0] data_q;
  logic [n_len-1:0]  row_q;
  logic [n_len-1:0]  col_q;
  logic              last_q;
  logic              valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n        = state;
    mul_start      = 1'b0;
    busy           = 1'b1;
    valid          = 1'b0;
    checksum_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) state_n = S_LAUNCH;
      end
      S_LAUNCH: begin
        mul_start = 1'b1;
        state_n   = S_ARM;
      end
      // a done level left over from the last job must drop first
      S_ARM: begin
        if (!mul_done) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) state_n = S_FETCH;
      end
      S_FETCH: begin
        state_n = S_SEND;
      end
      S_SEND: begin
        valid = 1'b1;
        if (out_s.out_ready) begin
          state_n = last_q ? S_FINISH : S_FETCH;
        end
      end
      S_FINISH: begin
        checksum_valid = 1'b1;
        state_n        = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_i      <= '0;
      z_j      <= '0;
      data_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      last_q   <= 1'b0;
      checksum <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) begin
            checksum <= '0;
            z_i      <= '0;
            z_j      <= '0;
          end
        end
        S_WAIT: begin
          if (mul_done) begin
            z_i <= '0;
            z_j <= '0;
          end
        end
        S_FETCH: begin
          data_q <= z_out;
          row_q  <= z_i;
          col_q  <= z_j;
          last_q <= (z_i == LAST) && (z_j == LAST);
        end
        S_SEND: begin
          if (out_s.out_ready) begin
            checksum <= checksum + data_q;
            if (z_j == LAST) begin
              z_j <= '0;
              z_i <= (z_i == LAST) ? '0 : z_i + n_len'(1);
            end else begin
              z_j <= z_j + n_len'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_s.out_data  = data_q;
  assign out_s.out_row   = row_q;
  assign out_s.out_col   = col_q;
  assign out_s.out_valid = valid;
  assign out_s.out_last  = last_q & valid;

endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer: n=2 and n=1 streamers driven by random jobs;
// a queue-based scoreboard checks every streamed element and checksum.
module tb_result_streamer;
  import result_streamer_pkg::*;

  typedef struct {
    logic [31:0] d;
    int          r;
    int          c;
    bit          l;
  } el_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        go2, ms2, done2, busy2, cv2;
  logic [0:0]  zi2, zj2;
  logic [31:0] zout2, cs2, base2;

  logic        go1, ms1, done1, busy1, cv1;
  logic [0:0]  zi1, zj1;
  logic [31:0] zout1, cs1;

  result_streamer_if #(.n_len(1)) s2 ();
  result_streamer_if #(.n_len(1)) s1 ();

  assign zout2 = base2 + 32'(zi2) * 32'd16 + 32'(zj2);
  assign zout1 = 32'hFFFF_FFFF;

  result_streamer #(.n(2)) dut2 (
    .clk(clk), .rst(rst), .go(go2),
    .mul_start(ms2), .mul_done(done2),
    .z_i(zi2), .z_j(zj2), .z_out(zout2),
    .out_s(s2), .busy(busy2),
    .checksum(cs2), .checksum_valid(cv2)
  );

  result_streamer #(.n(1)) dut1 (
    .clk(clk), .rst(rst), .go(go1),
    .mul_start(ms1), .mul_done(done1),
    .z_i(zi1), .z_j(zj1), .z_out(zout1),
    .out_s(s1), .busy(busy1),
    .checksum(cs1), .checksum_valid(cv1)
  );

  int errors = 0;
  int checks = 0;
  int mode2  = 0;

  el_t         exp2[$];
  el_t         exp1[$];
  logic [31:0] cexp2[$];
  logic [31:0] cexp1[$];

  task automatic chk(input bit ok, input string name,
                     input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // sink for the n=2 stream: 0 always ready, 1 random,
  // 2 three stall cycles on (0,1), other: stall on (1,0)
  initial begin
    int hold;
    hold = 0;
    s2.out_ready = 1'b0;
    s1.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode2)
        0: s2.out_ready = 1'b1;
        1: s2.out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (s2.out_valid && s2.out_row == 1'b0 &&
              s2.out_col == 1'b1 && hold < 3) begin
            s2.out_ready = 1'b0;
            hold++;
          end else begin
            s2.out_ready = 1'b1;
          end
        end
        default: s2.out_ready = !(s2.out_valid &&
                   s2.out_row == 1'b1 && s2.out_col == 1'b0);
      endcase
      if (mode2 != 2) hold = 0;
    end
  end

  initial begin
    bit          stall, pcv, lexp;
    logic [31:0] pd, c;
    logic [1:0]  pidx;
    el_t         e;
    stall = 0; pcv = 0; pd = '0; pidx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0;
        pcv   = 0;
      end else begin
        lexp = s2.out_valid && s2.out_row == 1'b1 && s2.out_col == 1'b1;
        chk(s2.out_last == lexp, "last_flag2", s2.out_last, lexp);
        if (stall) begin
          chk(s2.out_valid, "hold_valid2", s2.out_valid, 1);
          chk(s2.out_data == pd, "hold_data2", s2.out_data, pd);
          chk({s2.out_row, s2.out_col} == pidx, "hold_idx2",
              {s2.out_row, s2.out_col}, pidx);
        end
        if (s2.out_valid && s2.out_ready) begin
          if (exp2.size() == 0) begin
            chk(0, "extra_elem2", s2.out_data, 0);
          end else begin
            e = exp2.pop_front();
            chk(s2.out_data == e.d, "data2", s2.out_data, e.d);
            chk(int'(s2.out_row) == e.r && int'(s2.out_col) == e.c &&
                s2.out_last == e.l, "idx2",
                {s2.out_row, s2.out_col, s2.out_last},
                {e.r[0], e.c[0], e.l});
          end
        end
        stall = s2.out_valid && !s2.out_ready;
        pd    = s2.out_data;
        pidx  = {s2.out_row, s2.out_col};
        if (cv2) begin
          chk(!pcv, "csum_pulse2", pcv, 0);
          if (cexp2.size() == 0) begin
            chk(0, "extra_csum2", cs2, 0);
          end else begin
            c = cexp2.pop_front();
            chk(cs2 == c, "csum2", cs2, c);
          end
        end
        pcv = cv2;
      end
    end
  end

  initial begin
    el_t         e;
    logic [31:0] c;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk(s1.out_last == s1.out_valid, "last_flag1",
            s1.out_last, s1.out_valid);
        if (s1.out_valid && s1.out_ready) begin
          if (exp1.size() == 0) begin
            chk(0, "extra_elem1", s1.out_data, 0);
          end else begin
            e = exp1.pop_front();
            chk(s1.out_data == e.d, "data1", s1.out_data, e.d);
          end
        end
        if (cv1) begin
          if (cexp1.size() == 0) begin
            chk(0, "extra_csum1", cs1, 0);
          end else begin
            c = cexp1.pop_front();
            chk(cs1 == c, "csum1", cs1, c);
          end
        end
      end
    end
  end

  task automatic run2(input logic [31:0] base, input int dly,
                      input bit stale, input bit extra_go,
                      input bit do_rst);
    bit          seen;
    logic [31:0] sum, v;
    sum   = '0;
    base2 = base;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        v = base + 32'(16 * i + j);
        exp2.push_back('{v, i, j, (i == 1 && j == 1)});
        sum += v;
      end
    end
    cexp2.push_back(sum);
    if (do_rst) mode2 = 4;
    done2 = stale;
    go2 = 1'b1;
    @(posedge clk); #1;
    go2 = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (ms2) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk(seen, "start_timeout2", seen, 1);
    @(posedge clk); #1;
    chk(!ms2, "start_pulse2", ms2, 0);
    go2 = extra_go;
    if (stale) begin
      @(posedge clk); #1;
      go2   = 1'b0;
      done2 = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        chk(!s2.out_valid, "stale_valid2", s2.out_valid, 0);
      end
    end else begin
      for (int k = 1; k < dly; k++) begin
        @(posedge clk); #1;
        go2 = 1'b0;
        chk(!s2.out_valid, "early_valid2", s2.out_valid, 0);
      end
    end
    go2   = 1'b0;
    done2 = 1'b1;
    if (do_rst) begin
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(posedge clk); #1;
        seen = s2.out_valid && s2.out_row == 1'b1 && s2.out_col == 1'b0;
      end
      chk(seen, "elem2_timeout", seen, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk(!busy2, "rst_busy2", busy2, 0);
      chk(!s2.out_valid, "rst_valid2", s2.out_valid, 0);
      rst = 1'b0;
      exp2.delete();
      cexp2.delete();
      mode2 = 0;
    end else begin
      for (int k = 0; k < 200 && busy2; k++) begin
        @(posedge clk); #1;
      end
      chk(!busy2, "job_timeout2", busy2, 0);
      chk(exp2.size() == 0, "elems_left2", exp2.size(), 0);
      chk(cexp2.size() == 0, "csum_left2", cexp2.size(), 0);
      repeat (2) begin
        @(posedge clk); #1;
      end
      chk(cs2 == sum, "csum_hold2", cs2, sum);
    end
  endtask

  task automatic run1();
    bit seen;
    exp1.push_back('{32'hFFFF_FFFF, 0, 0, 1'b1});
    cexp1.push_back(32'hFFFF_FFFF);
    done1 = 1'b0;
    go1 = 1'b1;
    @(posedge clk); #1;
    go1 = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (ms1) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk(seen, "start_timeout1", seen, 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    done1 = 1'b1;
    for (int k = 0; k < 50 && busy1; k++) begin
      @(posedge clk); #1;
    end
    chk(!busy1, "job_timeout1", busy1, 0);
    chk(exp1.size() == 0, "elems_left1", exp1.size(), 0);
    chk(cexp1.size() == 0, "csum_left1", cexp1.size(), 0);
    @(posedge clk); #1;
    chk(cs1 == 32'hFFFF_FFFF, "csum_hold1", cs1, 32'hFFFF_FFFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got 0 want 1");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    go2 = 1'b0; go1 = 1'b0;
    done2 = 1'b0; done1 = 1'b0;
    base2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk(!ms2 && !busy2 && !cv2, "rst_ctl2", {ms2, busy2, cv2}, 0);
    chk(zi2 == 0 && zj2 == 0, "rst_z2", {zi2, zj2}, 0);
    chk(s2.out_data == 0, "rst_data2", s2.out_data, 0);
    chk(s2.out_row == 0 && s2.out_col == 0, "rst_idx2",
        {s2.out_row, s2.out_col}, 0);
    chk(!s2.out_valid && !s2.out_last, "rst_valid2",
        {s2.out_valid, s2.out_last}, 0);
    chk(cs2 == 0, "rst_csum2", cs2, 0);
    chk(!ms1 && !busy1 && !cv1 && cs1 == 0, "rst_ctl1",
        {ms1, busy1, cv1, cs1}, 0);
    rst = 1'b0;

    run2(32'd0, 5, 0, 0, 0);
    mode2 = 2;
    run2(32'd0, 5, 0, 0, 0);
    mode2 = 0;
    run2(32'd0, 5, 1, 0, 0);
    run2(32'd0, 5, 0, 0, 1);
    run2(32'd0, 5, 0, 0, 0);
    run2(32'd0, 5, 0, 1, 0);
    run2(32'd0, 5, 0, 0, 0);
    run1();
    run1();

    for (int t = 0; t < 25; t++) begin
      mode2 = int'($urandom_range(0, 1));
      run2($urandom, int'($urandom_range(2, 9)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    mode2 = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
